conv2d: RTL
===========

CONV2D -- requirements
Module: conv2d

Interface
REQ-001 Parameters SHALL be: M, default 6, input image side; K, default 3, kernel side; pixel_bits, default 8, unsigned pixel/weight width.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  start request, sampled in IDLE only.
- strobe_signal_kernel  in  1  kernel_weight valid.
- kernel_weight  in  pixel_bits  kernel tap, row-major.
- strobe_signal_pixel  in  1  pixel valid.
- pixel  in  pixel_bits  input pixel, row-major.
- stride  in  clog2(K)+1  step size; 0 treated as 1; held stable while busy.
- result_address  in  clog2(M*M)  readout index, row-major.
- final_output  out  2*pixel_bits+clog2(K*K)  result at result_address (OW).
- out_dim  out  clog2(M+1)  output side length.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle completion pulse.

Function
REQ-003 States SHALL be IDLE, LOAD_KERNEL, LOAD_PIXELS, MAC, WRITE, DONE_STATE.
REQ-004 IDLE: on enable=1, clear tap/pixel counters, go to LOAD_KERNEL next cycle; enable outside IDLE is ignored.
REQ-005 LOAD_KERNEL: each strobe_signal_kernel cycle writes kernel_RAM[tap_counter] and increments; after K*K writes, go to LOAD_PIXELS.
REQ-006 LOAD_PIXELS: each strobe_signal_pixel cycle writes pixel_RAM[pixel_counter]; after M*M writes, go to MAC with row/col origin 0.
REQ-007 Strobes outside their load state are ignored; both asserted together only the one matching the state is taken.
REQ-008 MAC: one tap per cycle; accumulator += pixel_RAM[(r+i)*M + c+j] * kernel_RAM[i*K+j], taps in row-major order, exactly K*K cycles, accumulator cleared on entry.
REQ-009 WRITE: one cycle; store accumulator at result_RAM[out_index], increment out_index; advance c by stride; if c+stride+K > M, wrap c to 0 and advance r by stride; if r also overflows, go to DONE_STATE, else MAC.
REQ-010 Latency from last pixel strobe to done SHALL be out_dim^2*(K*K+1)+1 cycles.
REQ-011 out_dim SHALL equal floor((M-K)/stride)+1, computed by counting origins (no divider), valid from entry to MAC until next enable.
REQ-012 Accumulation SHALL be unsigned, full width OW; no overflow possible.
REQ-013 DONE_STATE: pulse done for one cycle, return to IDLE; result_RAM retained until next accepted enable.
REQ-014 final_output SHALL be combinational from result_RAM; indices >= out_dim^2 return 0.

Reset
REQ-015 rst asserted at any time, including mid-load or mid-MAC, SHALL force IDLE, clear all counters, accumulator, result_RAM and kernel_RAM, and drive done=0, busy=0, out_dim=0, final_output=0.
REQ-016 pixel_RAM need not be reset.

Configuration
REQ-017 With CONV2D_SATURATE_EN defined, WRITE SHALL clamp the stored value to 2^pixel_bits-1 (upper bits zero); without it the full OW-bit sum is stored.

Structure
REQ-018 Package conv_pkg SHALL hold the state encoding, OW and address-width constants.
REQ-019 The single multiplier SHALL be one instance of the existing multiply_unit; one MAC datapath, no per-tap replication.

Verification
REQ-020 M=4,K=3,stride=1, kernel all 1, pixels all 1 -> out_dim=2, four outputs = 9, done after 2*2*10+1 cycles.
REQ-021 M=6,K=3,stride=2, kernel centre=1 others 0, pixel[n]=n -> out_dim=2, outputs 7,9,19,21.
REQ-022 Pixels 255, kernel 255, M=3 -> output 585225 without CONV2D_SATURATE_EN, 255 with it.
REQ-023 rst pulsed during MAC, then enable -> immediate IDLE, all outputs 0, following full run gives correct results.
REQ-024 enable and strobes toggled during MAC; strobe_signal_pixel during LOAD_KERNEL -> ignored, results unchanged.
REQ-025 stride=0 with M=4,K=3 -> behaves as stride 1, out_dim=2; result_address=15 reads 0.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: state encoding, default geometry and width helpers shared by the
// conv2d block and its test bench.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KERNEL,
        LOAD_PIXELS,
        MAC,
        WRITE,
        DONE_STATE
    } state_t;

    localparam int DEFAULT_M          = 6;
    localparam int DEFAULT_K          = 3;
    localparam int DEFAULT_PIXEL_BITS = 8;

    // Accumulator / result width: a full product plus room for K*K additions.
    function automatic int out_width(input int pb, input int k);
        return 2 * pb + $clog2(k * k);
    endfunction

    // Address width of an m x m row-major memory.
    function automatic int addr_width(input int m);
        return $clog2(m * m);
    endfunction

    // Width able to hold an output side length of 0..m.
    function automatic int dim_width(input int m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/multiply_unit.sv
// multiply_unit: unsigned combinational W x W -> 2W multiplier; the single
// multiplier shared by every tap of the conv2d MAC datapath.
module multiply_unit #(
    parameter int W = 8
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] product
);

    assign product = {{W{1'b0}}, a} * {{W{1'b0}}, b};

endmodule

// File: rtl/conv2d.sv
// conv2d: loads a KxK kernel and an MxM image through strobed ports, then
// slides the kernel over the image with a programmable stride using one
// shared multiplier, one tap per cycle. Results are read back combinationally
// by row-major index.
// Optional build macro CONV2D_SATURATE_EN: when defined, every stored result
// is clamped to 2^pixel_bits-1; otherwise the full-width sum is stored.
module conv2d
    import conv_pkg::*;
#(
    parameter int M          = DEFAULT_M,
    parameter int K          = DEFAULT_K,
    parameter int pixel_bits = DEFAULT_PIXEL_BITS
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  enable,
    input  logic                                  strobe_signal_kernel,
    input  logic [pixel_bits-1:0]                 kernel_weight,
    input  logic                                  strobe_signal_pixel,
    input  logic [pixel_bits-1:0]                 pixel,
    input  logic [$clog2(K):0]                    stride,
    input  logic [addr_width(M)-1:0]              result_address,
    output logic [out_width(pixel_bits, K)-1:0]   final_output,
    output logic [dim_width(M)-1:0]               out_dim,
    output logic                                  busy,
    output logic                                  done
);

    localparam int OW  = out_width(pixel_bits, K);
    localparam int AW  = addr_width(M);
    localparam int DW  = dim_width(M);
    localparam int SW  = $clog2(K) + 1;
    localparam int KAW = $clog2(K * K);
    localparam int IW  = $clog2(K + 1);

`ifdef CONV2D_SATURATE_EN
    localparam logic [OW-1:0] MAX_PIXEL = OW'((1 << pixel_bits) - 1);
`endif

    state_t state;
    state_t next_state;

    logic [KAW-1:0]        tap_counter;
    logic [AW-1:0]         pixel_counter;
    logic [IW-1:0]         tap_i;
    logic [IW-1:0]         tap_j;
    logic [DW-1:0]         row;
    logic [DW-1:0]         col;
    logic [AW-1:0]         out_index;
    logic [OW-1:0]         acc;
    logic [OW-1:0]         write_value;
    logic [2*pixel_bits-1:0] product;

    logic [pixel_bits-1:0] kernel_ram [K*K];
    logic [pixel_bits-1:0] pixel_ram  [M*M];
    logic [OW-1:0]         result_ram [M*M];

    logic [SW-1:0]  stride_eff;
    logic           last_kernel;
    logic           last_pixel;
    logic           last_tap;
    logic           col_wrap;
    logic           row_wrap;
    logic [AW-1:0]  pixel_addr;
    logic [KAW-1:0] kernel_addr;

    // Output side length found by counting legal window origins for stride s.
    function automatic logic [DW-1:0] count_origins(input logic [SW-1:0] s);
        int n;
        n = 0;
        for (int p = 0; p <= M; p++) begin
            if (p * int'(s) + K <= M) n++;
        end
        return DW'(n);
    endfunction

    // Decode stride, terminal counts, window wrap flags and MAC addresses.
    always_comb begin
        stride_eff  = (stride == '0) ? SW'(1) : stride;
        last_kernel = strobe_signal_kernel && (tap_counter == KAW'(K * K - 1));
        last_pixel  = strobe_signal_pixel && (pixel_counter == AW'(M * M - 1));
        last_tap    = (tap_i == IW'(K - 1)) && (tap_j == IW'(K - 1));
        col_wrap    = (int'(col) + int'(stride_eff) + K) > M;
        row_wrap    = (int'(row) + int'(stride_eff) + K) > M;
        pixel_addr  = AW'((int'(row) + int'(tap_i)) * M + int'(col) + int'(tap_j));
        kernel_addr = KAW'(int'(tap_i) * K + int'(tap_j));
    end

    multiply_unit #(
        .W(pixel_bits)
    ) mul (
        .a       (pixel_ram[pixel_addr]),
        .b       (kernel_ram[kernel_addr]),
        .product (product)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:        if (enable) next_state = LOAD_KERNEL;
            LOAD_KERNEL: if (last_kernel) next_state = LOAD_PIXELS;
            LOAD_PIXELS: if (last_pixel) next_state = MAC;
            MAC:         if (last_tap) next_state = WRITE;
            WRITE:       next_state = (col_wrap && row_wrap) ? DONE_STATE : MAC;
            DONE_STATE:  next_state = IDLE;
            default:     next_state = IDLE;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE_STATE);
    end

    // Load counters, tap walker, window origin, accumulator and out_dim.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_counter   <= '0;
            pixel_counter <= '0;
            tap_i         <= '0;
            tap_j         <= '0;
            row           <= '0;
            col           <= '0;
            out_index     <= '0;
            acc           <= '0;
            out_dim       <= '0;
        end else begin
            if (state == MAC) begin
                acc <= acc + OW'(product);
                if (tap_j == IW'(K - 1)) begin
                    tap_j <= '0;
                    tap_i <= tap_i + IW'(1);
                end else begin
                    tap_j <= tap_j + IW'(1);
                end
            end else begin
                acc   <= '0;
                tap_i <= '0;
                tap_j <= '0;
            end
            case (state)
                IDLE: begin
                    if (enable) begin
                        tap_counter   <= '0;
                        pixel_counter <= '0;
                        row           <= '0;
                        col           <= '0;
                        out_index     <= '0;
                        out_dim       <= '0;
                    end
                end
                LOAD_KERNEL: begin
                    if (strobe_signal_kernel) tap_counter <= tap_counter + KAW'(1);
                end
                LOAD_PIXELS: begin
                    if (strobe_signal_pixel) pixel_counter <= pixel_counter + AW'(1);
                    if (last_pixel) begin
                        row       <= '0;
                        col       <= '0;
                        out_index <= '0;
                        out_dim   <= count_origins(stride_eff);
                    end
                end
                WRITE: begin
                    out_index <= out_index + AW'(1);
                    if (!col_wrap) begin
                        col <= col + DW'(stride_eff);
                    end else begin
                        col <= '0;
                        row <= row_wrap ? '0 : row + DW'(stride_eff);
                    end
                end
                default: ;
            endcase
        end
    end

    // Kernel memory: cleared by reset, written only while loading the kernel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < K * K; n++) kernel_ram[n] <= '0;
        end else if (state == LOAD_KERNEL && strobe_signal_kernel) begin
            kernel_ram[tap_counter] <= kernel_weight;
        end
    end

    // Pixel memory: written only while loading pixels; contents need no reset.
    always_ff @(posedge clk) begin
        if (state == LOAD_PIXELS && strobe_signal_pixel) begin
            pixel_ram[pixel_counter] <= pixel;
        end
    end

    // Value committed to result memory at the end of each window.
    always_comb begin
`ifdef CONV2D_SATURATE_EN
        write_value = (acc > MAX_PIXEL) ? MAX_PIXEL : acc;
`else
        write_value = acc;
`endif
    end

    // Result memory: cleared by reset, one entry written per WRITE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < M * M; n++) result_ram[n] <= '0;
        end else if (state == WRITE) begin
            result_ram[out_index] <= write_value;
        end
    end

    // Readout: indices past the produced outputs read as zero.
    always_comb begin
        if (int'(result_address) < int'(out_dim) * int'(out_dim)) begin
            final_output = result_ram[result_address];
        end else begin
            final_output = '0;
        end
    end

endmodule
